// File: rtl/mc_main_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_main_fsm_pkg
// Shared definitions for the multi-cycle RISC-V main control FSM:
//   - state_e   : 4-bit state encoding (also exported on state_o for debug)
//   - OP_*      : opcode constants recognised by the decoder
//   - SRCA_*, SRCB_*, RES_*, IMM_*, ALUOP_* : datapath select encodings
//   - ctrl_t    : bundle of the per-state (Moore) control outputs
//   - ctrlFor() : maps a state to its Moore control bundle
// ---------------------------------------------------------------------------
package mc_main_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // fetch marks the FETCH state, whose IRWrite/PCUpdate are further
   // qualified by mem_ready; jump is the unconditional PC load of JAL.
   typedef struct packed {
      logic       memReq;
      logic       adrSrc;
      logic       fetch;
      logic       jump;
      logic       branch;
      logic       regWrite;
      logic       memWrite;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic [1:0] aluOp;
   } ctrl_t;

   // Every field starts at zero so states only list what they assert;
   // TRAP and unused encodings therefore drive an all-zero bundle.
   function automatic ctrl_t ctrlFor(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memReq    = 1'b1;
            c.fetch     = 1'b1;
            c.aluSrcA   = SRCA_PC;
            c.aluSrcB   = SRCB_FOUR;
            c.aluOp     = ALUOP_ADD;
            c.resultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            c.aluSrcA = SRCA_OLDPC;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.aluSrcA = SRCA_RS1;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.memReq    = 1'b1;
            c.adrSrc    = 1'b1;
            c.resultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            c.regWrite  = 1'b1;
            c.resultSrc = RES_DATA;
         end
         S_MEMWRITE: begin
            c.memReq   = 1'b1;
            c.memWrite = 1'b1;
            c.adrSrc   = 1'b1;
         end
         S_EXECR: begin
            c.aluSrcA = SRCA_RS1;
            c.aluSrcB = SRCB_RS2;
            c.aluOp   = ALUOP_FUNCT;
         end
         S_EXECI: begin
            c.aluSrcA = SRCA_RS1;
            c.aluSrcB = SRCB_IMM;
            c.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.regWrite  = 1'b1;
            c.resultSrc = RES_ALUOUT;
         end
         S_BEQ: begin
            c.branch    = 1'b1;
            c.aluSrcA   = SRCA_RS1;
            c.aluSrcB   = SRCB_RS2;
            c.aluOp     = ALUOP_SUB;
            c.resultSrc = RES_ALUOUT;
         end
         S_JAL: begin
            c.jump      = 1'b1;
            c.aluSrcA   = SRCA_OLDPC;
            c.aluSrcB   = SRCB_FOUR;
            c.aluOp     = ALUOP_ADD;
            c.resultSrc = RES_ALUOUT;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_main_fsm_imm_src_dec.sv
// ---------------------------------------------------------------------------
// imm_src_dec
// Purely combinational opcode -> immediate-format decode, independent of
// the FSM state.
//   opcode_i  [6:0] : instruction opcode field
//   imm_src_o [1:0] : immediate format (I/S/B/J), I for anything unknown
// ---------------------------------------------------------------------------
module imm_src_dec
   import mc_main_fsm_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [1:0] imm_src_o
);

   // Unknown opcodes fall back to the I format so the output is never X.
   always_comb begin
      imm_src_o = IMM_I;
      case (opcode_i)
         OP_LOAD,
         OP_ITYPE:  imm_src_o = IMM_I;
         OP_STORE:  imm_src_o = IMM_S;
         OP_BRANCH: imm_src_o = IMM_B;
         OP_JAL:    imm_src_o = IMM_J;
         default:   imm_src_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/mc_main_fsm.sv
// ---------------------------------------------------------------------------
// mc_main_fsm
// Main control FSM of a multi-cycle RISC-V core (lw, sw, R/I-type, beq, jal).
// Parameters:
//   EN_JAL   : 1 decodes jal, 0 sends it to TRAP
//   MEM_WAIT : 1 honours mem_ready, 0 treats it as always 1
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   opcode, mem_ready   : instruction opcode, memory-done handshake
//   mem_req, AdrSrc     : memory request and address select (PC / ALUOut)
//   IRWrite, PCUpdate   : IR load, unconditional PC load
//   Branch              : conditional PC load (qualified by Zero outside)
//   RegWrite, MemWrite  : register-file / data-memory write enables
//   ALUSrcA, ALUSrcB    : ALU operand selects
//   ResultSrc, ALUOp    : result select, ALU-decoder class
//   ImmSrc              : immediate format, combinational from opcode
//   illegal             : sticky unsupported-opcode flag
//   state_o             : current state encoding for debug
// ---------------------------------------------------------------------------
module mc_main_fsm
   import mc_main_fsm_pkg::*;
#(
   parameter bit EN_JAL   = 1'b1,
   parameter bit MEM_WAIT = 1'b1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl_q;
   logic   illegal_q;
   logic   memReadyEff;
   logic   fetchGo;

   assign memReadyEff = MEM_WAIT ? mem_ready : 1'b1;

   // Next-state selection. Memory states hold until the access completes;
   // TRAP is absorbing and unused encodings also land in TRAP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (memReadyEff) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD,
               OP_STORE:  state_d = S_MEMADR;
               OP_RTYPE:  state_d = S_EXECR;
               OP_ITYPE:  state_d = S_EXECI;
               OP_BRANCH: state_d = S_BEQ;
               OP_JAL: begin
                  if (EN_JAL) state_d = S_JAL;
                  else        state_d = S_TRAP;
               end
               default:   state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LOAD) state_d = S_MEMREAD;
            else                   state_d = S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (memReadyEff) state_d = S_MEMWB;
         end
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: begin
            if (memReadyEff) state_d = S_FETCH;
         end
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   // State, Moore outputs and the sticky illegal flag share one register
   // stage. Outputs are registered from the next state, so they line up
   // with state_q; reset loads the FETCH bundle, making FETCH outputs
   // visible while rst_n is low and killing any write strobe at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ctrl_q    <= ctrlFor(S_FETCH);
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrlFor(state_d);
         illegal_q <= illegal_q | (state_d == S_TRAP);
      end
   end

   // The FETCH strobes depend on this cycle's mem_ready, so they are
   // qualified combinationally; they are held off while in reset so the PC
   // never moves while the FSM is pinned in FETCH.
   assign fetchGo   = ctrl_q.fetch & memReadyEff & rst_n;
   assign IRWrite   = fetchGo;
   assign PCUpdate  = ctrl_q.jump | fetchGo;

   assign mem_req   = ctrl_q.memReq;
   assign AdrSrc    = ctrl_q.adrSrc;
   assign Branch    = ctrl_q.branch;
   assign RegWrite  = ctrl_q.regWrite;
   assign MemWrite  = ctrl_q.memWrite;
   assign ALUSrcA   = ctrl_q.aluSrcA;
   assign ALUSrcB   = ctrl_q.aluSrcB;
   assign ResultSrc = ctrl_q.resultSrc;
   assign ALUOp     = ctrl_q.aluOp;
   assign illegal   = illegal_q;
   assign state_o   = state_q;

   imm_src_dec uImmSrcDec (
      .opcode_i  (opcode),
      .imm_src_o (ImmSrc)
   );

endmodule

// File: tb/tb_mc_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_main_fsm
// Drives three mc_main_fsm instances side by side: inst0 default
// parameters, inst1 with EN_JAL=0, inst2 with MEM_WAIT=0. Each instance is
// tracked by an instruction-path model that expands an opcode into the
// list of states the instruction walks through.
// ---------------------------------------------------------------------------
module tb_mc_main_fsm;
   import mc_main_fsm_pkg::*;

   localparam int N = 3;

   typedef struct packed {
      logic       memReq;
      logic       adrSrc;
      logic       irWrite;
      logic       pcUpdate;
      logic       branch;
      logic       regWrite;
      logic       memWrite;
      logic [1:0] srcA;
      logic [1:0] srcB;
      logic [1:0] resSrc;
      logic [1:0] aluOp;
   } outs_t;

   typedef struct {
      logic [6:0] op;
      logic [1:0] imm;
   } immVec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode    [N];
   logic       memReady  [N];
   logic       memReq    [N];
   logic       adrSrc    [N];
   logic       irWrite   [N];
   logic       pcUpdate  [N];
   logic       branch    [N];
   logic       regWrite  [N];
   logic       memWrite  [N];
   logic [1:0] aluSrcA   [N];
   logic [1:0] aluSrcB   [N];
   logic [1:0] resultSrc [N];
   logic [1:0] aluOp     [N];
   logic [1:0] immSrc    [N];
   logic       illegal   [N];
   logic [3:0] stateO    [N];

   int checks   = 0;
   int failures = 0;

   state_e  mState   [N];
   state_e  path     [N][3];
   int      pathLen  [N];
   int      pathIdx  [N];
   logic    mIllegal [N];
   immVec_t immTable [10];

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Three DUT copies covering the default and both parameter variants.
   for (genvar g = 0; g < N; g++) begin : gDut
      mc_main_fsm #(
         .EN_JAL   (g != 1),
         .MEM_WAIT (g != 2)
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .opcode    (opcode[g]),
         .mem_ready (memReady[g]),
         .mem_req   (memReq[g]),
         .AdrSrc    (adrSrc[g]),
         .IRWrite   (irWrite[g]),
         .PCUpdate  (pcUpdate[g]),
         .Branch    (branch[g]),
         .RegWrite  (regWrite[g]),
         .MemWrite  (memWrite[g]),
         .ALUSrcA   (aluSrcA[g]),
         .ALUSrcB   (aluSrcB[g]),
         .ResultSrc (resultSrc[g]),
         .ALUOp     (aluOp[g]),
         .ImmSrc    (immSrc[g]),
         .illegal   (illegal[g]),
         .state_o   (stateO[g])
      );
   end

   task automatic checkOutput(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t",
                  name, inst, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] expImm(logic [6:0] op);
      if (op == OP_STORE)       return 2'b01;
      else if (op == OP_BRANCH) return 2'b10;
      else if (op == OP_JAL)    return 2'b11;
      else                      return 2'b00;
   endfunction

   // Output table per state; rdy is the effective memory handshake.
   function automatic outs_t expectFor(state_e s, logic rdy);
      outs_t o;
      o = '0;
      case (s)
         S_FETCH:    begin o.memReq = 1; o.srcB = 2; o.resSrc = 2;
                           o.irWrite = rdy; o.pcUpdate = rdy; end
         S_DECODE:   begin o.srcA = 1; o.srcB = 1; end
         S_MEMADR:   begin o.srcA = 2; o.srcB = 1; end
         S_MEMREAD:  begin o.memReq = 1; o.adrSrc = 1; end
         S_MEMWB:    begin o.regWrite = 1; o.resSrc = 1; end
         S_MEMWRITE: begin o.memReq = 1; o.memWrite = 1; o.adrSrc = 1; end
         S_EXECR:    begin o.srcA = 2; o.srcB = 0; o.aluOp = 2; end
         S_EXECI:    begin o.srcA = 2; o.srcB = 1; o.aluOp = 2; end
         S_ALUWB:    begin o.regWrite = 1; end
         S_BEQ:      begin o.branch = 1; o.srcA = 2; o.aluOp = 1; end
         S_JAL:      begin o.pcUpdate = 1; o.srcA = 1; o.srcB = 2; end
         default:    o = '0;
      endcase
      return o;
   endfunction

   function automatic logic rdyEff(int g);
      return (g == 2) ? 1'b1 : memReady[g];
   endfunction

   task automatic modelReset(int g);
      mState[g]   = S_FETCH;
      mIllegal[g] = 1'b0;
      pathLen[g]  = 0;
      pathIdx[g]  = 0;
   endtask

   // At DECODE the opcode is expanded into the remaining states of the
   // instruction; later steps simply walk that list, stalling in the two
   // memory states while the handshake is low.
   task automatic modelStep(int g);
      logic rdy;
      rdy = rdyEff(g);
      if (rst_n == 1'b0) begin
         modelReset(g);
      end else begin
         case (mState[g])
            S_TRAP: ;
            S_FETCH: if (rdy) mState[g] = S_DECODE;
            S_DECODE: begin
               pathLen[g] = 1;
               path[g][0] = S_TRAP;
               if (opcode[g] == OP_LOAD) begin
                  path[g][0] = S_MEMADR; path[g][1] = S_MEMREAD;
                  path[g][2] = S_MEMWB; pathLen[g] = 3;
               end else if (opcode[g] == OP_STORE) begin
                  path[g][0] = S_MEMADR; path[g][1] = S_MEMWRITE; pathLen[g] = 2;
               end else if (opcode[g] == OP_RTYPE) begin
                  path[g][0] = S_EXECR; path[g][1] = S_ALUWB; pathLen[g] = 2;
               end else if (opcode[g] == OP_ITYPE) begin
                  path[g][0] = S_EXECI; path[g][1] = S_ALUWB; pathLen[g] = 2;
               end else if (opcode[g] == OP_BRANCH) begin
                  path[g][0] = S_BEQ;
               end else if (opcode[g] == OP_JAL && g != 1) begin
                  path[g][0] = S_JAL; path[g][1] = S_ALUWB; pathLen[g] = 2;
               end
               mState[g]  = path[g][0];
               pathIdx[g] = 1;
            end
            default: begin
               if (!((mState[g] == S_MEMREAD || mState[g] == S_MEMWRITE) && !rdy)) begin
                  if (pathIdx[g] < pathLen[g]) begin
                     mState[g] = path[g][pathIdx[g]];
                     pathIdx[g]++;
                  end else begin
                     mState[g] = S_FETCH;
                  end
               end
            end
         endcase
         if (mState[g] == S_TRAP) mIllegal[g] = 1'b1;
      end
   endtask

   // Called at the falling edge after inputs are set: lets them settle and
   // compares every instance against its model.
   task automatic applyStimulus();
      outs_t act;
      #1;
      for (int g = 0; g < N; g++) begin
         act.memReq   = memReq[g];
         act.adrSrc   = adrSrc[g];
         act.irWrite  = irWrite[g];
         act.pcUpdate = pcUpdate[g];
         act.branch   = branch[g];
         act.regWrite = regWrite[g];
         act.memWrite = memWrite[g];
         act.srcA     = aluSrcA[g];
         act.srcB     = aluSrcB[g];
         act.resSrc   = resultSrc[g];
         act.aluOp    = aluOp[g];
         checkOutput("state", g, 32'(stateO[g]), 32'(mState[g]));
         checkOutput("illegal", g, 32'(illegal[g]), 32'(mIllegal[g]));
         checkOutput("outputs", g, 32'(act), 32'(expectFor(mState[g], rdyEff(g))));
         checkOutput("immsrc", g, 32'(immSrc[g]), 32'(expImm(opcode[g])));
      end
   endtask

   task automatic finishCycle();
      for (int g = 0; g < N; g++) modelStep(g);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Mid-cycle asynchronous reset pulse, released before the next edge.
   task automatic pulseReset();
      #1;
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < N; g++) begin
         checkOutput("async_rst_state", g, 32'(stateO[g]), 32'(S_FETCH));
         checkOutput("async_rst_illegal", g, 32'(illegal[g]), 32'd0);
         checkOutput("async_rst_regwrite", g, 32'(regWrite[g]), 32'd0);
         checkOutput("async_rst_memwrite", g, 32'(memWrite[g]), 32'd0);
         checkOutput("async_rst_memreq", g, 32'(memReq[g]), 32'd1);
         modelReset(g);
      end
      rst_n = 1'b1;
   endtask

   task automatic resetAll();
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < N; g++) begin
         checkOutput("rst_state", g, 32'(stateO[g]), 32'(S_FETCH));
         checkOutput("rst_illegal", g, 32'(illegal[g]), 32'd0);
         checkOutput("rst_memreq", g, 32'(memReq[g]), 32'd1);
         checkOutput("rst_alusrcb", g, 32'(aluSrcB[g]), 32'(SRCB_FOUR));
         checkOutput("rst_resultsrc", g, 32'(resultSrc[g]), 32'(RES_ALURESULT));
         checkOutput("rst_regwrite", g, 32'(regWrite[g]), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < N; g++) modelReset(g);
      rst_n = 1'b1;
   endtask

   task automatic setAll(logic [6:0] op, logic rdy);
      for (int g = 0; g < N; g++) begin
         opcode[g]   = op;
         memReady[g] = rdy;
      end
   endtask

   function automatic logic [6:0] pickOpcode();
      int r;
      r = $urandom_range(0, 15);
      case (r)
         0, 1:    return OP_LOAD;
         2, 3:    return OP_STORE;
         4, 5, 6: return OP_RTYPE;
         7, 8, 9: return OP_ITYPE;
         10, 11:  return OP_BRANCH;
         12, 13:  return OP_JAL;
         14:      return 7'($urandom_range(0, 127));
         default: return OP_RTYPE;
      endcase
   endfunction

   // Main sequence: ImmSrc table under reset, directed multi-cycle corner
   // cases, then a long randomized run against the path model.
   initial begin
      state_e lwSeq  [6];
      state_e swSeq  [7];
      logic   swRdy  [7];
      logic   swMw   [7];
      state_e beqSeq [4];
      state_e rSeq   [4];
      bit     trapped;

      immTable = '{
         '{OP_LOAD,   2'b00}, '{OP_ITYPE,  2'b00}, '{OP_STORE, 2'b01},
         '{OP_BRANCH, 2'b10}, '{OP_JAL,    2'b11}, '{OP_RTYPE, 2'b00},
         '{7'b0000000, 2'b00}, '{7'b1111111, 2'b00}, '{7'b0110111, 2'b00},
         '{7'b1100111, 2'b00}};
      lwSeq  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_FETCH};
      swSeq  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_MEMWRITE, S_FETCH};
      swRdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      swMw   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      beqSeq = '{S_FETCH, S_DECODE, S_BEQ, S_FETCH};
      rSeq   = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};

      rst_n = 1'b0;
      setAll(OP_RTYPE, 1'b1);
      @(negedge clk);

      for (int t = 0; t < 10; t++) begin
         for (int g = 0; g < N; g++) opcode[g] = immTable[t].op;
         #1;
         for (int g = 0; g < N; g++)
            checkOutput("immsrc_table", g, 32'(immSrc[g]), 32'(immTable[t].imm));
      end

      // lw with memory always ready
      setAll(OP_LOAD, 1'b1);
      resetAll();
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         checkOutput("lw_state", 0, 32'(stateO[0]), 32'(lwSeq[i]));
         checkOutput("lw_regwrite", 0, 32'(regWrite[0]), 32'(i == 4));
         if (i == 4) checkOutput("lw_resultsrc", 0, 32'(resultSrc[0]), 32'(RES_DATA));
         finishCycle();
      end

      // sw with two wait cycles in MEMWRITE
      setAll(OP_STORE, 1'b1);
      resetAll();
      for (int i = 0; i < 7; i++) begin
         for (int g = 0; g < N; g++) memReady[g] = swRdy[i];
         applyStimulus();
         checkOutput("sw_state", 0, 32'(stateO[0]), 32'(swSeq[i]));
         checkOutput("sw_memwrite", 0, 32'(memWrite[0]), 32'(swMw[i]));
         checkOutput("sw_regwrite", 0, 32'(regWrite[0]), 32'd0);
         finishCycle();
      end

      // beq completes in three cycles
      setAll(OP_BRANCH, 1'b1);
      resetAll();
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("beq_state", 0, 32'(stateO[0]), 32'(beqSeq[i]));
         checkOutput("beq_branch", 0, 32'(branch[0]), 32'(i == 2));
         checkOutput("beq_immsrc", 0, 32'(immSrc[0]), 32'(IMM_B));
         if (i == 2) checkOutput("beq_aluop", 0, 32'(aluOp[0]), 32'(ALUOP_SUB));
         finishCycle();
      end

      // jal on the EN_JAL=0 instance traps; async reset clears illegal
      setAll(OP_JAL, 1'b1);
      resetAll();
      for (int i = 0; i < 13; i++) begin
         applyStimulus();
         checkOutput("jal_trap_state", 1, 32'(stateO[1]),
                     32'((i == 0) ? S_FETCH : (i == 1) ? S_DECODE : S_TRAP));
         checkOutput("jal_trap_illegal", 1, 32'(illegal[1]), 32'(i >= 2));
         finishCycle();
      end
      applyStimulus();
      pulseReset();
      finishCycle();

      // lw reset while waiting in MEMREAD: no write-back afterwards
      setAll(OP_LOAD, 1'b1);
      resetAll();
      for (int i = 0; i < 5; i++) begin
         for (int g = 0; g < N; g++) memReady[g] = (i < 3);
         applyStimulus();
         checkOutput("lw_wait_state", 0, 32'(stateO[0]), 32'(lwSeq[(i < 3) ? i : 3]));
         if (i == 4) pulseReset();
         finishCycle();
      end
      for (int i = 0; i < 3; i++) begin
         for (int g = 0; g < N; g++) memReady[g] = 1'b1;
         applyStimulus();
         checkOutput("lw_abort_regwrite", 0, 32'(regWrite[0]), 32'd0);
         finishCycle();
      end

      // R-type loop on the MEM_WAIT=0 instance with mem_ready held low
      setAll(OP_RTYPE, 1'b0);
      resetAll();
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         checkOutput("rloop_state", 2, 32'(stateO[2]), 32'(rSeq[i % 4]));
         checkOutput("rloop_regwrite", 2, 32'(regWrite[2]), 32'((i % 4) == 3));
         checkOutput("rloop_irwrite", 2, 32'(irWrite[2]), 32'((i % 4) == 0));
         finishCycle();
      end

      // Randomized run: new opcode only while an instance sits in FETCH
      resetAll();
      for (int c = 0; c < 3000; c++) begin
         trapped = 1'b0;
         for (int g = 0; g < N; g++) begin
            if (mState[g] == S_FETCH) opcode[g] = pickOpcode();
            memReady[g] = ($urandom_range(0, 3) != 0);
            if (mState[g] == S_TRAP) trapped = 1'b1;
         end
         applyStimulus();
         if ($urandom_range(0, 59) == 0 || (trapped && $urandom_range(0, 7) == 0))
            pulseReset();
         finishCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
